// File: rtl/set_assoc_cache_if.sv
// set_assoc_cache_if: request, response and eviction signals of the set-associative cache.
interface set_assoc_cache_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [LINE_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_hit;
    logic [LINE_WIDTH-1:0] resp_rdata;
    logic                  evict_valid;
    logic [ADDR_WIDTH-1:0] evict_addr;
    logic [LINE_WIDTH-1:0] evict_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_hit, resp_rdata, evict_valid, evict_addr, evict_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_hit, resp_rdata, evict_valid, evict_addr, evict_data
    );
endinterface

// File: rtl/set_assoc_cache.sv
// set_assoc_cache: SETS x WAYS cache with per-set CLOCK replacement and an eviction port.
module set_assoc_cache #(
    parameter int ADDR_WIDTH = 8,
    parameter int LINE_WIDTH = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 4
) (
    input logic              clock,
    input logic              reset_n,
    set_assoc_cache_if.slave bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef enum logic [1:0] {IDLE, LOOKUP, SWEEP} state_t;

    state_t                state_q, state_d;
    logic                  cap_write;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [LINE_WIDTH-1:0] cap_wdata;

    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAYS-1:0]       ref_q   [SETS];
    logic [WAY_W-1:0]      ptr_q   [SETS];
    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic [LINE_WIDTH-1:0] data_q  [SETS][WAYS];

    logic                  resp_valid_q, resp_hit_q, evict_valid_q;
    logic [LINE_WIDTH-1:0] resp_rdata_q, evict_data_q;
    logic [ADDR_WIDTH-1:0] evict_addr_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tg;
    logic [WAY_W-1:0] hit_way, inv_way, cur, way_sel;
    logic             hit, any_inv, cur_ref;
    logic             line_we, ref_we, ref_val, ptr_inc, resp_d, evict_d;

    assign idx     = cap_addr[IDX_W-1:0];
    assign tg      = cap_addr[ADDR_WIDTH-1:IDX_W];
    assign cur     = ptr_q[idx];
    assign cur_ref = ref_q[idx][cur];

    // Descending scan so the lowest matching / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tg) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        line_we = 1'b0;
        ref_we  = 1'b0;
        ref_val = 1'b0;
        ptr_inc = 1'b0;
        resp_d  = 1'b0;
        evict_d = 1'b0;
        way_sel = hit_way;
        case (state_q)
            IDLE: state_d = bus.req_valid ? LOOKUP : IDLE;
            LOOKUP: begin
                if (hit || !cap_write || any_inv) begin
                    way_sel = hit ? hit_way : inv_way;
                    line_we = cap_write;
                    ref_we  = hit || cap_write;
                    ref_val = 1'b1;
                    resp_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                way_sel = cur;
                ref_we  = 1'b1;
                ptr_inc = 1'b1;
                ref_val = !cur_ref;
                line_we = !cur_ref;
                evict_d = !cur_ref;
                resp_d  = !cur_ref;
                state_d = cur_ref ? SWEEP : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cap_write     <= 1'b0;
            cap_addr      <= '0;
            cap_wdata     <= '0;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_rdata_q  <= '0;
            evict_valid_q <= 1'b0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ref_q[s]   <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q       <= state_d;
            resp_valid_q  <= resp_d;
            evict_valid_q <= evict_d;
            if (state_q == IDLE && bus.req_valid) begin
                cap_write <= bus.req_write;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
            end
            if (resp_d) begin
                resp_hit_q   <= state_q == LOOKUP && hit;
                resp_rdata_q <= (state_q == LOOKUP && hit && !cap_write) ? data_q[idx][hit_way] : '0;
            end
            if (evict_d) begin
                evict_addr_q <= {tag_q[idx][cur], idx};
                evict_data_q <= data_q[idx][cur];
            end
            if (line_we)
                valid_q[idx][way_sel] <= 1'b1;
            if (ref_we)
                ref_q[idx][way_sel] <= ref_val;
            if (ptr_inc)
                ptr_q[idx] <= cur + WAY_W'(1);
        end
    end

    // Line payload needs no reset: valid bits gate every use of it.
    always_ff @(posedge clock) begin
        if (line_we) begin
            tag_q[idx][way_sel]  <= tg;
            data_q[idx][way_sel] <= cap_wdata;
        end
    end

    assign bus.req_ready   = state_q == IDLE;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_hit    = resp_hit_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.evict_valid = evict_valid_q;
    assign bus.evict_addr  = evict_addr_q;
    assign bus.evict_data  = evict_data_q;
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb_set_assoc_cache: directed checks of hits, fills, CLOCK eviction, backpressure and mid-sweep reset.
module tb_set_assoc_cache;
    logic clock = 1'b0;
    logic reset_n = 1'b0;

    set_assoc_cache_if #(.ADDR_WIDTH(8), .LINE_WIDTH(32)) bus ();

    set_assoc_cache #(.ADDR_WIDTH(8), .LINE_WIDTH(32), .WAYS(2), .SETS(4)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic        hit, ev, flag;
    logic [31:0] rdata, edata;
    logic [7:0]  eaddr;

    localparam logic [31:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004, E = 32'hEEEE_0005, F = 32'hFFFF_0006;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency counts rising edges from the accept edge up to the response cycle.
    task automatic req(input logic w, input logic [7:0] a, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
            bus.req_valid = 1'b0;
        end while (!bus.resp_valid && lat < 20);
        if (!bus.resp_valid)
            chk("resp_timeout", bus.resp_valid, 1);
        hit   = bus.resp_hit;
        rdata = bus.resp_rdata;
        ev    = bus.evict_valid;
        eaddr = bus.evict_addr;
        edata = bus.evict_data;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_evict_valid", bus.evict_valid, 0);
        chk("rst_rdata", bus.resp_rdata, 0);
        chk("rst_evict_addr", bus.evict_addr, 0);
        reset_n = 1'b1;

        req(0, 8'h15, 0);
        chk("t1_lat", lat, 2);
        chk("t1_hit", hit, 0);
        chk("t1_rdata", rdata, 0);
        chk("t1_ev", ev, 0);

        req(1, 8'h15, 32'hDEADBEEF);
        chk("t2_wr_lat", lat, 2);
        chk("t2_wr_hit", hit, 0);
        req(0, 8'h15, 0);
        chk("t2_rd_lat", lat, 2);
        chk("t2_rd_hit", hit, 1);
        chk("t2_rd_data", rdata, 32'hDEADBEEF);

        req(1, 8'h15, A);
        chk("t3_wa_hit", hit, 1);
        req(1, 8'h25, B);
        chk("t3_wb_lat", lat, 2);
        chk("t3_wb_ev", ev, 0);
        req(1, 8'h35, C);
        chk("t3_wc_lat", lat, 5);
        chk("t3_wc_ev", ev, 1);
        chk("t3_wc_eaddr", eaddr, 8'h15);
        chk("t3_wc_edata", edata, A);
        chk("t3_wc_hit", hit, 0);
        req(0, 8'h15, 0);
        chk("t3_rd15_hit", hit, 0);
        req(0, 8'h25, 0);
        chk("t3_rd25_hit", hit, 1);
        chk("t3_rd25_data", rdata, B);

        pulse_reset();
        req(1, 8'h15, A);
        req(1, 8'h25, B);
        req(1, 8'h35, C);
        chk("t4_wc_lat", lat, 5);
        req(1, 8'h45, D);
        chk("t4_wd_lat", lat, 3);
        chk("t4_wd_ev", ev, 1);
        chk("t4_wd_eaddr", eaddr, 8'h25);
        chk("t4_wd_edata", edata, B);
        req(0, 8'h35, 0);
        chk("t4_rd35_hit", hit, 1);
        chk("t4_rd35_data", rdata, C);
        req(0, 8'h45, 0);
        chk("t4_rd45_data", rdata, D);

        req(1, 8'h16, E);
        chk("t5_w16_lat", lat, 2);
        chk("t5_w16_ev", ev, 0);
        chk("t5_w16_hit", hit, 0);
        // Request held high through the sweep; ptr of set 1 must still point at way 0.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h55;
        bus.req_wdata = F;
        lat  = 0;
        flag = 1'b1;
        do begin
            @(posedge clock);
            #1;
            lat++;
            if (!bus.resp_valid && bus.req_ready)
                flag = 1'b0;
        end while (!bus.resp_valid && lat < 20);
        chk("t5_hold_lat", lat, 5);
        chk("t5_hold_ready_low", flag, 1);
        chk("t5_hold_ev", bus.evict_valid, 1);
        chk("t5_hold_eaddr", bus.evict_addr, 8'h35);
        chk("t5_hold_edata", bus.evict_data, C);
        chk("t5_resp_ready", bus.req_ready, 1);
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h16;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        chk("t5_pulse_end", bus.resp_valid, 0);
        chk("t5_reaccept", bus.req_ready, 0);
        @(posedge clock);
        #1;
        chk("t5_rd16_valid", bus.resp_valid, 1);
        chk("t5_rd16_hit", bus.resp_hit, 1);
        chk("t5_rd16_data", bus.resp_rdata, E);
        chk("t5_rd16_noev", bus.evict_valid, 0);
        chk("t5_edata_held", bus.evict_data, C);

        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h65;
        bus.req_wdata = A;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_resp_valid", bus.resp_valid, 0);
        chk("t6_evict_valid", bus.evict_valid, 0);
        chk("t6_ready", bus.req_ready, 1);
        chk("t6_edata", bus.evict_data, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        flag = 1'b0;
        repeat (4) begin
            @(posedge clock);
            #1;
            if (bus.resp_valid)
                flag = 1'b1;
        end
        chk("t6_no_resp", flag, 0);
        req(0, 8'h35, 0);
        chk("t6_rd35_hit", hit, 0);
        req(0, 8'h45, 0);
        chk("t6_rd45_hit", hit, 0);
        req(0, 8'h55, 0);
        chk("t6_rd55_hit", hit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
